// File: rtl/irq_fetch_seq_if.sv
// Handshake/bus bundle between the fetch-stage interrupt sequencer and its environment.
interface irq_fetch_seq_if #(
    parameter int unsigned NUM_DEV = 8
) ();
    logic [NUM_DEV-1:0] irq_req;
    logic [NUM_DEV-1:0] irq_mask;
    logic               mie;
    logic               branch;
    logic               stall;
    logic [31:0]        next_pc;
    logic               mret;
    logic               if_id_freeze;
    logic               irq_if_ctrl;
    logic [5:0]         device_id;
    logic [31:0]        mepc;
    logic [NUM_DEV-1:0] irq_ack;
    logic               irq_busy;

    modport slave (
        input  irq_req, irq_mask, mie, branch, stall, next_pc, mret,
        output if_id_freeze, irq_if_ctrl, device_id, mepc, irq_ack, irq_busy
    );

    modport master (
        output irq_req, irq_mask, mie, branch, stall, next_pc, mret,
        input  if_id_freeze, irq_if_ctrl, device_id, mepc, irq_ack, irq_busy
    );
endinterface

// File: rtl/irq_fetch_seq.sv
// Interrupt sequencer for the instruction-fetch stage: pends masked requests,
// picks the lowest-index winner, waits for a quiet pipeline, then issues a
// one-cycle freeze/vector handshake and blocks further vectoring until mret.
// Optional: define IRQ_EDGE_EN for rising-edge capture instead of level capture.
module irq_fetch_seq #(
    parameter int unsigned NUM_DEV      = 8,
    parameter int unsigned DRAIN_CYCLES = 2
) (
    input  logic           clk,
    input  logic           rst,
    irq_fetch_seq_if.slave bus
);
    localparam int unsigned CNT_W = 4;
    localparam int unsigned ID_W  = 6;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRAIN  = 2'd1,
        VECTOR = 2'd2,
        IN_ISR = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NUM_DEV-1:0] pending_q, pending_d;
    logic [NUM_DEV-1:0] cap;
    logic [NUM_DEV-1:0] ack_q, ack_d;
    logic [ID_W-1:0]    dev_q, dev_d;
    logic [ID_W-1:0]    win_id;
    logic [31:0]        mepc_q, mepc_d;
    logic               freeze_q, freeze_d;
    logic               ctrl_q, ctrl_d;
    logic               busy_q, busy_d;
    logic               win_found;

`ifdef IRQ_EDGE_EN
    logic [NUM_DEV-1:0] irq_req_q;

    // Previous request levels, so a held line pends only once per rising edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) irq_req_q <= '0;
        else     irq_req_q <= bus.irq_req;
    end

    assign cap = bus.irq_req & ~irq_req_q & bus.irq_mask;
`else
    assign cap = bus.irq_req & bus.irq_mask;
`endif

    // The ack issued this cycle beats a same-cycle request on that bit.
    assign pending_d = (pending_q | cap) & ~ack_q;

    // Fixed priority: lowest pending index wins.
    always_comb begin
        win_id    = '0;
        win_found = 1'b0;
        for (int unsigned i = 0; i < NUM_DEV; i++) begin
            if (!win_found && pending_q[i]) begin
                win_id    = ID_W'(i);
                win_found = 1'b1;
            end
        end
    end

    // Next-state and next-output logic; outputs are registered so they line up with the state.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        dev_d    = dev_q;
        mepc_d   = mepc_q;
        ack_d    = '0;
        freeze_d = 1'b0;
        ctrl_d   = 1'b0;
        busy_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.mie && (pending_q != '0)) begin
                    state_d = DRAIN;
                    cnt_d   = '0;
                end
            end
            DRAIN: begin
                if (!bus.mie || (pending_q == '0)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (bus.branch || bus.stall) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_W'(DRAIN_CYCLES - 1)) begin
                    state_d  = VECTOR;
                    cnt_d    = '0;
                    dev_d    = win_id;
                    ack_d    = NUM_DEV'(1) << win_id;
                    freeze_d = 1'b1;
                    ctrl_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            VECTOR: begin
                mepc_d  = bus.next_pc;
                state_d = IN_ISR;
                busy_d  = 1'b1;
            end
            IN_ISR: begin
                busy_d = 1'b1;
                if (bus.mret) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, pending and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            pending_q <= '0;
            ack_q     <= '0;
            dev_q     <= '0;
            mepc_q    <= '0;
            freeze_q  <= 1'b0;
            ctrl_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            ack_q     <= ack_d;
            dev_q     <= dev_d;
            mepc_q    <= mepc_d;
            freeze_q  <= freeze_d;
            ctrl_q    <= ctrl_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.if_id_freeze = freeze_q;
    assign bus.irq_if_ctrl  = ctrl_q;
    assign bus.device_id    = dev_q;
    assign bus.mepc         = mepc_q;
    assign bus.irq_ack      = ack_q;
    assign bus.irq_busy     = busy_q;
endmodule

// File: tb/tb_irq_fetch_seq.sv
// Directed bench for irq_fetch_seq (NUM_DEV=8, DRAIN_CYCLES=2).
module tb_irq_fetch_seq;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    irq_fetch_seq_if #(.NUM_DEV(8)) bus ();

    irq_fetch_seq #(.NUM_DEV(8), .DRAIN_CYCLES(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; sample point is 1 ns after the rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Step until irq_if_ctrl is seen; n = cycles taken, -1 if none within max.
    task automatic wait_vector(input int max, output int n);
        n = -1;
        for (int i = 1; i <= max; i++) begin
            cyc();
            if (bus.irq_if_ctrl === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.irq_req = '0; bus.irq_mask = '0; bus.mie = 1'b0; bus.branch = 1'b0;
        bus.stall = 1'b0; bus.next_pc = '0; bus.mret = 1'b0;
        cyc(); cyc();
        checks++;
        if ({bus.if_id_freeze, bus.irq_if_ctrl, bus.device_id, bus.irq_ack, bus.irq_busy, bus.mepc} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got frz=%b ctl=%b id=%0d ack=%h busy=%b mepc=%h, want all 0",
                     bus.if_id_freeze, bus.irq_if_ctrl, bus.device_id, bus.irq_ack, bus.irq_busy, bus.mepc);
        end
        rst = 1'b0;
        cyc(); cyc();
        checks++;
        if ({bus.if_id_freeze, bus.irq_if_ctrl, bus.irq_ack, bus.irq_busy} !== '0) begin
            errors++;
            $display("FAIL post_reset_idle: got frz=%b ctl=%b ack=%h busy=%b, want 0",
                     bus.if_id_freeze, bus.irq_if_ctrl, bus.irq_ack, bus.irq_busy);
        end
    endtask

    task automatic test_basic_vector();
        int n;
        bus.irq_mask = 8'hFF; bus.mie = 1'b1; bus.next_pc = 32'h0000_0120;
        bus.irq_req = 8'h04;
        wait_vector(10, n);
        checks++;
        if (n !== 4) begin
            errors++;
            $display("FAIL basic_latency: got %0d cycles, want 4", n);
        end
        checks++;
        if ({bus.if_id_freeze, bus.device_id, bus.irq_ack, bus.irq_busy} !== {1'b1, 6'd2, 8'h04, 1'b0}) begin
            errors++;
            $display("FAIL basic_vector: got frz=%b id=%0d ack=%h busy=%b, want frz=1 id=2 ack=04 busy=0",
                     bus.if_id_freeze, bus.device_id, bus.irq_ack, bus.irq_busy);
        end
        bus.irq_req = '0;
        cyc();
        bus.next_pc = 32'h0000_0400;
        checks++;
        if ({bus.if_id_freeze, bus.irq_if_ctrl, bus.irq_ack, bus.irq_busy, bus.mepc}
            !== {1'b0, 1'b0, 8'h00, 1'b1, 32'h0000_0120}) begin
            errors++;
            $display("FAIL basic_in_isr: got frz=%b ctl=%b ack=%h busy=%b mepc=%h, want 0 0 00 1 00000120",
                     bus.if_id_freeze, bus.irq_if_ctrl, bus.irq_ack, bus.irq_busy, bus.mepc);
        end
        cyc(); cyc();
        checks++;
        if ({bus.irq_busy, bus.mepc} !== {1'b1, 32'h0000_0120}) begin
            errors++;
            $display("FAIL basic_busy_hold: got busy=%b mepc=%h, want 1 00000120", bus.irq_busy, bus.mepc);
        end
        bus.mret = 1'b1;
        cyc();
        bus.mret = 1'b0;
        checks++;
        if (bus.irq_busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_mret: got busy=%b, want 0", bus.irq_busy);
        end
        wait_vector(8, n);
        checks++;
        if (n !== -1) begin
            errors++;
            $display("FAIL basic_no_repeat: got vector after %0d cycles, want none", n);
        end
    endtask

    task automatic test_priority_mask();
        int n;
        int exp_n;
        bus.irq_mask = 8'hFD;
        bus.irq_req  = 8'h0A;
        wait_vector(10, n);
        checks++;
        if ({n, bus.device_id, bus.irq_ack} !== {32'sd4, 6'd3, 8'h08}) begin
            errors++;
            $display("FAIL prio_first: got n=%0d id=%0d ack=%h, want n=4 id=3 ack=08",
                     n, bus.device_id, bus.irq_ack);
        end
        cyc();
        bus.mret = 1'b1;
        cyc();
        bus.mret = 1'b0;
`ifdef IRQ_EDGE_EN
        exp_n = -1;
`else
        exp_n = 3;
`endif
        wait_vector(10, n);
        checks++;
        if (n !== exp_n) begin
            errors++;
            $display("FAIL prio_level_repeat: got n=%0d, want %0d", n, exp_n);
        end
`ifndef IRQ_EDGE_EN
        checks++;
        if ({bus.device_id, bus.irq_ack} !== {6'd3, 8'h08}) begin
            errors++;
            $display("FAIL prio_second_id: got id=%0d ack=%h, want id=3 ack=08", bus.device_id, bus.irq_ack);
        end
`endif
        bus.irq_req = 8'h02;
        cyc();
        bus.mret = 1'b1;
        cyc();
        bus.mret = 1'b0;
        wait_vector(10, n);
        checks++;
        if (n !== -1) begin
            errors++;
            $display("FAIL prio_masked_only: got vector after %0d cycles id=%0d, want none", n, bus.device_id);
        end
        bus.irq_req  = '0;
        bus.irq_mask = 8'hFF;
        cyc();
    endtask

    task automatic test_drain_holdoff();
        int early;
        early = 0;
        bus.irq_req = 8'h04;
        cyc(); cyc();
        for (int k = 0; k < 6; k++) begin
            bus.branch = (k % 2 == 0);
            cyc();
            if (bus.irq_if_ctrl !== 1'b0 || bus.if_id_freeze !== 1'b0) early++;
        end
        checks++;
        if (early !== 0) begin
            errors++;
            $display("FAIL drain_no_vector_during_branch: got %0d vector cycles, want 0", early);
        end
        bus.branch = 1'b0;
        cyc();
        checks++;
        if ({bus.irq_if_ctrl, bus.if_id_freeze, bus.device_id} !== {1'b1, 1'b1, 6'd2}) begin
            errors++;
            $display("FAIL drain_vector_after_quiet: got ctl=%b frz=%b id=%0d, want 1 1 2",
                     bus.irq_if_ctrl, bus.if_id_freeze, bus.device_id);
        end
        bus.irq_req = '0;
        cyc();
        bus.mret = 1'b1;
        cyc();
        bus.mret = 1'b0;
    endtask

    task automatic test_nesting_blocked();
        int n;
        int bad;
        bad = 0;
        bus.irq_req = 8'h01;
        wait_vector(10, n);
        checks++;
        if ({n, bus.device_id} !== {32'sd4, 6'd0}) begin
            errors++;
            $display("FAIL nest_first: got n=%0d id=%0d, want n=4 id=0", n, bus.device_id);
        end
        bus.irq_req = '0;
        cyc();
        bus.irq_req = 8'h20;
        for (int k = 0; k < 6; k++) begin
            cyc();
            if (bus.irq_if_ctrl !== 1'b0 || bus.if_id_freeze !== 1'b0 || bus.irq_busy !== 1'b1) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL nest_blocked: got %0d bad cycles in ISR, want 0", bad);
        end
        bus.irq_req = '0;
        bus.mret = 1'b1;
        cyc();
        bus.mret = 1'b0;
        wait_vector(10, n);
        checks++;
        if ({n, bus.device_id, bus.irq_ack} !== {32'sd3, 6'd5, 8'h20}) begin
            errors++;
            $display("FAIL nest_after_mret: got n=%0d id=%0d ack=%h, want n=3 id=5 ack=20",
                     n, bus.device_id, bus.irq_ack);
        end
        cyc();
        bus.mret = 1'b1;
        cyc();
        bus.mret = 1'b0;
    endtask

    task automatic test_abort_reset();
        int n;
        bus.irq_req = 8'h04;
        cyc(); cyc();
        bus.mie = 1'b0;
        bus.irq_req = '0;
        wait_vector(8, n);
        checks++;
        if ({n, bus.irq_ack, bus.irq_busy} !== {-32'sd1, 8'h00, 1'b0}) begin
            errors++;
            $display("FAIL abort_mie_drop: got n=%0d ack=%h busy=%b, want no vector", n, bus.irq_ack, bus.irq_busy);
        end
        bus.mie = 1'b1;
        wait_vector(8, n);
        checks++;
        if ({n, bus.device_id} !== {32'sd3, 6'd2}) begin
            errors++;
            $display("FAIL abort_resume: got n=%0d id=%0d, want n=3 id=2", n, bus.device_id);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.if_id_freeze, bus.irq_if_ctrl, bus.device_id, bus.irq_ack, bus.irq_busy, bus.mepc} !== '0) begin
            errors++;
            $display("FAIL reset_in_vector: got frz=%b ctl=%b id=%0d ack=%h busy=%b mepc=%h, want all 0",
                     bus.if_id_freeze, bus.irq_if_ctrl, bus.device_id, bus.irq_ack, bus.irq_busy, bus.mepc);
        end
        cyc(); cyc();
        rst = 1'b0;
        wait_vector(8, n);
        checks++;
        if (n !== -1) begin
            errors++;
            $display("FAIL reset_clears_pending: got vector after %0d cycles, want none", n);
        end
    endtask

    task automatic test_held_request();
        int vecs;
        int exp_vecs;
        vecs = 0;
        bus.irq_req = 8'h02;
        for (int i = 0; i < 20; i++) begin
            bus.mret = bus.irq_busy;
            cyc();
            if (bus.irq_if_ctrl === 1'b1) begin
                vecs++;
                checks++;
                if (bus.device_id !== 6'd1) begin
                    errors++;
                    $display("FAIL held_id: got id=%0d, want 1", bus.device_id);
                end
            end
        end
        bus.irq_req = '0;
        bus.mret = bus.irq_busy;
        cyc();
        bus.mret = 1'b0;
`ifdef IRQ_EDGE_EN
        exp_vecs = 1;
`else
        exp_vecs = 4;
`endif
        checks++;
        if (vecs !== exp_vecs) begin
            errors++;
            $display("FAIL held_vector_count: got %0d vectors, want %0d", vecs, exp_vecs);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic_vector();
        test_priority_mask();
        test_drain_holdoff();
        test_nesting_blocked();
        test_abort_reset();
        test_held_request();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
